// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder: turns the registered EX/MEM request into a
// req/gnt/rvalid bus transaction, formats load data and raises access exceptions.
module dmem_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          cpurst_n,
  input  logic          mem_en,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [2:0]    mem_op,
  output logic          mem_stall,
  output logic [31:0]   mem_rdata,
  output logic          mem_rvalid,
  output logic          mem_exp,
  output logic [1:0]    mem_exp_cause,
  output logic          sram_req,
  output logic          sram_we,
  output logic [AW-3:0] sram_addr,
  output logic [3:0]    sram_be,
  output logic [31:0]   sram_wdata,
  input  logic          sram_gnt,
  input  logic          sram_rvalid,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            req_q, req_d, we_q, we_d;
  logic [AW-3:0]   addr_q, addr_d;
  logic [3:0]      be_q, be_d, lane_be;
  logic [31:0]     wdata_q, wdata_d, lane_wdata;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            illegal_op, misalign, exc_idle, timeout_hit, wait_done;

  // Stores with op[2] set would be unsigned stores, which do not exist.
  assign illegal_op  = (mem_op == 3'b011) || (mem_op[2:1] == 2'b11) || (mem_wr && mem_op[2]);
  assign misalign    = ((mem_op[1:0] == 2'b01) && mem_addr[0]) ||
                       ((mem_op[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00));
  assign exc_idle    = (state_q == IDLE) && mem_en && (illegal_op || misalign);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign wait_done   = (state_q == WAIT) && (sram_rvalid || timeout_hit);

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = mem_wdata;
    case (mem_op[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << mem_addr[1:0];
        lane_wdata = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // A granted transaction always runs to rvalid or timeout, flush or not.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_en && !illegal_op && !misalign) state_d = REQ;
      REQ:  if (sram_gnt) state_d = WAIT;
            else if (!mem_en) state_d = IDLE;
      WAIT: if (sram_rvalid || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: if (state_d == REQ) begin
        req_d   = 1'b1;
        we_d    = mem_wr;
        addr_d  = mem_addr[AW-1:2];
        be_d    = lane_be;
        wdata_d = lane_wdata;
      end
      REQ: if (state_d != REQ) begin
        req_d = 1'b0;
        if (state_d == IDLE) we_d = 1'b0;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (state_d == IDLE) we_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_stall     = cpurst_n && mem_en && !wait_done && !exc_idle;
    mem_rvalid    = cpurst_n && (state_q == WAIT) && sram_rvalid && mem_en && !we_q;
    mem_exp       = 1'b0;
    mem_exp_cause = 2'b00;
    if (cpurst_n && exc_idle) begin
      mem_exp       = 1'b1;
      mem_exp_cause = illegal_op ? 2'b10 : 2'b01;
    end else if (cpurst_n && (state_q == WAIT) && !sram_rvalid && timeout_hit) begin
      mem_exp       = 1'b1;
      mem_exp_cause = 2'b11;
    end
  end

  // Load lane select; the pipeline holds mem_addr/mem_op stable while stalled.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (mem_addr[1:0])
      2'd0:    b = sram_rdata[7:0];
      2'd1:    b = sram_rdata[15:8];
      2'd2:    b = sram_rdata[23:16];
      default: b = sram_rdata[31:24];
    endcase
    h = mem_addr[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (mem_op)
      3'b000:  mem_rdata = {{24{b[7]}}, b};
      3'b001:  mem_rdata = {{16{h[15]}}, h};
      3'b100:  mem_rdata = {24'h0, b};
      3'b101:  mem_rdata = {16'h0, h};
      default: mem_rdata = sram_rdata;
    endcase
  end

  assign sram_req   = req_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_be    = be_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with TIMEOUT=4: loads, stores, exceptions,
// flushes, bus timeout, asynchronous reset and back-to-back requests.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        cpurst_n;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_op;
  logic        mem_stall, mem_rvalid, mem_exp;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_exp_cause;
  logic        sram_req, sram_we, sram_gnt, sram_rvalid;
  logic [29:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata, sram_rdata;

  int checks = 0;
  int failures = 0;

  dmem_ctrl #(.TIMEOUT(4), .AW(32)) dut (
    .clk(clk), .cpurst_n(cpurst_n),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_exp(mem_exp), .mem_exp_cause(mem_exp_cause),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_wdata(sram_wdata), .sram_gnt(sram_gnt), .sram_rvalid(sram_rvalid),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic wr, input logic [31:0] a, input logic [2:0] op,
                     input logic [31:0] wd);
    mem_en = 1'b1; mem_wr = wr; mem_addr = a; mem_op = op; mem_wdata = wd;
  endtask

  task automatic idle_inputs();
    mem_en = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_op = 3'b010; mem_wdata = '0;
    sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = '0;
  endtask

  task automatic test_reset();
    cpurst_n = 1'b0;
    idle_inputs();
    req(1'b0, 32'h101, 3'b011, 32'h0);
    #12;
    checks++; if (sram_req !== 1'b0 || sram_we !== 1'b0 || sram_be !== 4'h0) begin
      failures++; $display("FAIL reset_bus req=%b we=%b be=%h expected 0", sram_req, sram_we, sram_be); end
    checks++; if (sram_addr !== 30'h0 || sram_wdata !== 32'h0) begin
      failures++; $display("FAIL reset_data addr=%h wdata=%h expected 0", sram_addr, sram_wdata); end
    checks++; if (mem_stall !== 1'b0 || mem_exp !== 1'b0 || mem_rvalid !== 1'b0 || mem_exp_cause !== 2'b00) begin
      failures++; $display("FAIL reset_outs stall=%b exp=%b rvalid=%b cause=%b expected 0",
                           mem_stall, mem_exp, mem_rvalid, mem_exp_cause); end
    idle_inputs();
    @(negedge clk); cpurst_n = 1'b1;
  endtask

  task automatic test_lw();
    nxt(); req(1'b0, 32'h100, 3'b010, 32'h0); sram_gnt = 1'b1;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b1 || sram_req !== 1'b0) begin
      failures++; $display("FAIL lw_idle stall=%b req=%b expected 1 0", mem_stall, sram_req); end
    nxt(); @(negedge clk);
    checks++; if (sram_req !== 1'b1 || sram_addr !== 30'h40 || sram_be !== 4'hf || sram_we !== 1'b0 || mem_stall !== 1'b1) begin
      failures++; $display("FAIL lw_req req=%b addr=%h be=%h we=%b stall=%b expected 1 40 f 0 1",
                           sram_req, sram_addr, sram_be, sram_we, mem_stall); end
    nxt(); sram_rvalid = 1'b1; sram_rdata = 32'hDEADBEEF; @(negedge clk);
    checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'hDEADBEEF || mem_stall !== 1'b0 || sram_req !== 1'b0) begin
      failures++; $display("FAIL lw_resp rvalid=%b rdata=%h stall=%b req=%b expected 1 deadbeef 0 0",
                           mem_rvalid, mem_rdata, mem_stall, sram_req); end
    nxt(); idle_inputs(); @(negedge clk);
    checks++; if (mem_rvalid !== 1'b0 || sram_req !== 1'b0) begin
      failures++; $display("FAIL lw_done rvalid=%b req=%b expected 0 0", mem_rvalid, sram_req); end
  endtask

  task automatic test_load_fmt();
    logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h104};
    logic [2:0]  ops   [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b010};
    logic [31:0] rds   [6] = '{32'h80123456, 32'h80123456, 32'hBEEF1234, 32'hBEEF1234, 32'h00007F00, 32'h5A5AA5A5};
    logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFFBEEF, 32'h0000007F, 32'h5A5AA5A5};
    for (int i = 0; i < 6; i++) begin
      nxt(); req(1'b0, addrs[i], ops[i], 32'h0); sram_gnt = 1'b1;
      nxt();
      nxt(); sram_rvalid = 1'b1; sram_rdata = rds[i]; @(negedge clk);
      checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== exps[i]) begin
        failures++; $display("FAIL load_fmt[%0d] rvalid=%b rdata=%h expected 1 %h", i, mem_rvalid, mem_rdata, exps[i]); end
      nxt(); idle_inputs();
    end
  endtask

  task automatic test_store();
    logic [31:0] addrs [3] = '{32'h22, 32'h103, 32'h10};
    logic [2:0]  ops   [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] wds   [3] = '{32'h1234, 32'hAB, 32'hCAFEF00D};
    logic [3:0]  ebe   [3] = '{4'b1100, 4'b1000, 4'b1111};
    logic [31:0] ewd   [3] = '{32'h12341234, 32'hABABABAB, 32'hCAFEF00D};
    logic [29:0] ead   [3] = '{30'h8, 30'h40, 30'h4};
    for (int i = 0; i < 3; i++) begin
      nxt(); req(1'b1, addrs[i], ops[i], wds[i]); sram_gnt = 1'b1;
      nxt(); @(negedge clk);
      checks++; if (sram_req !== 1'b1 || sram_we !== 1'b1 || sram_be !== ebe[i] || sram_wdata !== ewd[i] || sram_addr !== ead[i]) begin
        failures++; $display("FAIL store_bus[%0d] req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 %b %h %h",
                             i, sram_req, sram_we, sram_be, sram_wdata, sram_addr, ebe[i], ewd[i], ead[i]); end
      nxt(); sram_rvalid = 1'b1; @(negedge clk);
      checks++; if (mem_stall !== 1'b0 || mem_rvalid !== 1'b0) begin
        failures++; $display("FAIL store_ack[%0d] stall=%b rvalid=%b expected 0 0", i, mem_stall, mem_rvalid); end
      nxt(); idle_inputs();
    end
  endtask

  task automatic test_exceptions();
    logic [31:0] addrs [6] = '{32'h101, 32'h100, 32'h103, 32'h100, 32'h101, 32'h102};
    logic [2:0]  ops   [6] = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b111, 3'b010};
    logic        wrs   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  ecs   [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 6; i++) begin
      nxt(); req(wrs[i], addrs[i], ops[i], 32'h0); sram_gnt = 1'b1; @(negedge clk);
      checks++; if (mem_exp !== 1'b1 || mem_exp_cause !== ecs[i] || mem_stall !== 1'b0 || sram_req !== 1'b0) begin
        failures++; $display("FAIL exc[%0d] exp=%b cause=%b stall=%b req=%b expected 1 %b 0 0",
                             i, mem_exp, mem_exp_cause, mem_stall, sram_req, ecs[i]); end
    end
    nxt(); idle_inputs(); @(negedge clk);
    checks++; if (mem_exp !== 1'b0 || sram_req !== 1'b0) begin
      failures++; $display("FAIL exc_clear exp=%b req=%b expected 0 0", mem_exp, sram_req); end
  endtask

  task automatic test_flush_wait();
    nxt(); req(1'b0, 32'h200, 3'b010, 32'h0);
    for (int i = 0; i < 5; i++) nxt();
    @(negedge clk);
    checks++; if (sram_req !== 1'b1 || mem_stall !== 1'b1) begin
      failures++; $display("FAIL gnt_delay req=%b stall=%b expected 1 1", sram_req, mem_stall); end
    nxt(); sram_gnt = 1'b1;
    nxt(); sram_gnt = 1'b0; mem_en = 1'b0; @(negedge clk);
    checks++; if (sram_req !== 1'b0 || mem_stall !== 1'b0) begin
      failures++; $display("FAIL flush_wait req=%b stall=%b expected 0 0", sram_req, mem_stall); end
    nxt(); sram_rvalid = 1'b1; sram_rdata = 32'h11111111; @(negedge clk);
    checks++; if (mem_rvalid !== 1'b0 || mem_exp !== 1'b0) begin
      failures++; $display("FAIL flush_discard rvalid=%b exp=%b expected 0 0", mem_rvalid, mem_exp); end
    nxt(); sram_rvalid = 1'b0; req(1'b0, 32'h201, 3'b010, 32'h0); @(negedge clk);
    checks++; if (mem_exp !== 1'b1 || mem_exp_cause !== 2'b01) begin
      failures++; $display("FAIL flush_wait_idle exp=%b cause=%b expected 1 01", mem_exp, mem_exp_cause); end
    nxt(); idle_inputs();
  endtask

  task automatic test_flush_req();
    nxt(); req(1'b0, 32'h204, 3'b010, 32'h0);
    nxt(); @(negedge clk);
    checks++; if (sram_req !== 1'b1) begin
      failures++; $display("FAIL flush_req_pre req=%b expected 1", sram_req); end
    nxt(); mem_en = 1'b0;
    nxt(); req(1'b0, 32'h206, 3'b010, 32'h0); @(negedge clk);
    checks++; if (sram_req !== 1'b0 || mem_exp !== 1'b1 || mem_exp_cause !== 2'b01) begin
      failures++; $display("FAIL flush_req req=%b exp=%b cause=%b expected 0 1 01", sram_req, mem_exp, mem_exp_cause); end
    nxt(); idle_inputs();
  endtask

  task automatic test_timeout();
    nxt(); req(1'b0, 32'h300, 3'b010, 32'h0); sram_gnt = 1'b1;
    nxt();
    for (int i = 0; i < 3; i++) begin
      nxt(); sram_gnt = 1'b0; @(negedge clk);
      checks++; if (mem_exp !== 1'b0 || mem_stall !== 1'b1) begin
        failures++; $display("FAIL timeout_wait[%0d] exp=%b stall=%b expected 0 1", i, mem_exp, mem_stall); end
    end
    nxt(); @(negedge clk);
    checks++; if (mem_exp !== 1'b1 || mem_exp_cause !== 2'b11 || mem_stall !== 1'b0) begin
      failures++; $display("FAIL timeout exp=%b cause=%b stall=%b expected 1 11 0", mem_exp, mem_exp_cause, mem_stall); end
    nxt(); sram_rvalid = 1'b1; sram_rdata = 32'h22222222; @(negedge clk);
    checks++; if (mem_rvalid !== 1'b0 || mem_exp !== 1'b0 || mem_stall !== 1'b1) begin
      failures++; $display("FAIL late_rvalid rvalid=%b exp=%b stall=%b expected 0 0 1", mem_rvalid, mem_exp, mem_stall); end
    nxt(); mem_en = 1'b0; sram_rvalid = 1'b0;
    nxt(); idle_inputs();
  endtask

  task automatic test_reset_mid();
    nxt(); req(1'b0, 32'h400, 3'b010, 32'h0);
    nxt(); @(negedge clk);
    checks++; if (sram_req !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre req=%b expected 1", sram_req); end
    #2 cpurst_n = 1'b0;
    #1;
    checks++; if (sram_req !== 1'b0 || mem_stall !== 1'b0 || sram_be !== 4'h0) begin
      failures++; $display("FAIL rst_mid req=%b stall=%b be=%h expected 0 0 0", sram_req, mem_stall, sram_be); end
    nxt(); idle_inputs();
    nxt(); cpurst_n = 1'b1; @(negedge clk);
    checks++; if (sram_req !== 1'b0 || mem_stall !== 1'b0) begin
      failures++; $display("FAIL rst_mid_after req=%b stall=%b expected 0 0", sram_req, mem_stall); end
  endtask

  task automatic test_back_to_back();
    nxt(); req(1'b0, 32'h100, 3'b010, 32'h0); sram_gnt = 1'b1;
    nxt();
    nxt(); sram_rvalid = 1'b1; sram_rdata = 32'h01234567; @(negedge clk);
    checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h01234567) begin
      failures++; $display("FAIL b2b_first rvalid=%b rdata=%h expected 1 01234567", mem_rvalid, mem_rdata); end
    nxt(); sram_rvalid = 1'b0; mem_addr = 32'h104; @(negedge clk);
    checks++; if (mem_stall !== 1'b1 || mem_rvalid !== 1'b0) begin
      failures++; $display("FAIL b2b_idle stall=%b rvalid=%b expected 1 0", mem_stall, mem_rvalid); end
    nxt(); @(negedge clk);
    checks++; if (sram_req !== 1'b1 || sram_addr !== 30'h41) begin
      failures++; $display("FAIL b2b_req req=%b addr=%h expected 1 41", sram_req, sram_addr); end
    nxt(); sram_rvalid = 1'b1; sram_rdata = 32'h89ABCDEF; @(negedge clk);
    checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h89ABCDEF || mem_stall !== 1'b0) begin
      failures++; $display("FAIL b2b_second rvalid=%b rdata=%h stall=%b expected 1 89abcdef 0",
                           mem_rvalid, mem_rdata, mem_stall); end
    nxt(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_fmt();
    test_store();
    test_exceptions();
    test_flush_wait();
    test_flush_req();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
